// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and types for the FIFO stream reader
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 16;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

  // Words the reader owns once the current handshake retires: buffered + in flight - popped.
  function automatic logic [2:0] occupancy(input logic [1:0] buf_cnt,
                                           input logic       inflight,
                                           input logic       pop);
    return {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_skid_buf2.sv
// rtl/fifo_skid_buf2.sv - 2-entry circular output buffer with registered head word
module fifo_skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;
  logic             head_n;
  logic             tail_n;
  logic [1:0]       cnt_n;
  logic [WIDTH-1:0] head_word_n;

  always_comb begin
    head_n = head ^ pop;
    tail_n = tail ^ push;
    cnt_n  = cnt + {1'b0, push} - {1'b0, pop};
    // A word pushed into a buffer that is about to be empty becomes the new head directly.
    if (push && (tail == head_n)) head_word_n = din;
    else                          head_word_n = mem[head_n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      cnt     <= 2'd0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (flush) begin
      head    <= 1'b0;
      tail    <= 1'b0;
      cnt     <= 2'd0;
      m_valid <= 1'b0;
    end else begin
      if (push) mem[tail] <= din;
      head    <= head_n;
      tail    <= tail_n;
      cnt     <= cnt_n;
      m_valid <= (cnt_n != 2'd0);
      if (cnt_n != 2'd0) m_data <= head_word_n;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - pops a synchronous FIFO and presents words on a valid/ready stream
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] rd_count,
  output logic             busy
);

  logic       inflight;
  logic [1:0] buf_cnt;
  logic       pop;
  logic       push;

  // A handshake during flush is dropped along with everything else.
  assign pop        = m_valid && m_ready && !flush;
  assign push       = inflight && !flush;
  assign fifo_rd_en = !fifo_empty && !flush && (occupancy(buf_cnt, inflight, pop) < 3'd2);
  assign busy       = (buf_cnt != 2'd0) || inflight;

  fifo_skid_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .din    (fifo_data),
    .pop    (pop),
    .flush  (flush),
    .m_valid(m_valid),
    .m_data (m_data),
    .cnt    (buf_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) rd_count <= rd_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed bench for fifo_stream_reader with a behavioural FIFO
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       flush = 1'b0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic [3:0] rd_count;
  logic       busy;

  fifo_stream_reader #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .rd_count  (rd_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int delivered = 0;

  logic [7:0] fmem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  bit popped_empty = 1'b0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (!rst_n) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) popped_empty <= 1'b1;
      else begin
        fifo_data <= fmem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  logic [7:0] got [$];
  int got_cyc [$];
  int cyc = 0;
  bit hold_err = 1'b0;
  bit occ_err = 1'b0;
  logic pv = 1'b0, pr = 1'b0, pf = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) pv = 1'b0;
    else begin
      if (pv && !pr && !pf && (m_valid !== 1'b1 || m_data !== pd)) hold_err = 1'b1;
      if (int'(dut.buf_cnt) + int'(dut.inflight) > 2) occ_err = 1'b1;
      if (m_valid && m_ready && !flush) begin
        got.push_back(m_data);
        got_cyc.push_back(cyc);
      end
      pv = m_valid; pr = m_ready; pf = flush; pd = m_data;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [7:0] v);
    fmem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_got(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (got.size() >= n) ok = 1'b1;
      else step();
    end
    if (got.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    step(2);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got=%0h exp=0", m_data); end
    total++; if (rd_count !== 4'd0) begin bad++; $display("FAIL reset_rd_count got=%0d exp=0", rd_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    rst_n = 1'b1;
    step(5);
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL idle_rd_en got=%0b exp=0", fifo_rd_en); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL idle_m_valid got=%0b exp=0", m_valid); end
    total++; if (rd_count !== 4'd0) begin bad++; $display("FAIL idle_rd_count got=%0d exp=0", rd_count); end
  endtask

  task automatic test_stream();
    int base, errs;
    bit ok;
    m_ready = 1'b1;
    base = got.size();
    for (int i = 1; i <= 16; i++) put(8'(i));
    #1;
    total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL stream_first_rd_en got=%0b exp=1", fifo_rd_en); end
    step();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL stream_lat_n1 got=%0b exp=0", m_valid); end
    step();
    total++; if (m_valid !== 1'b1 || m_data !== 8'h01) begin bad++; $display("FAIL stream_lat_n2 got=%0b/%0h exp=1/01", m_valid, m_data); end
    wait_got(base + 16, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL stream_timeout got=%0d exp=%0d", got.size() - base, 16); end
    errs = 0;
    for (int i = 0; i < 16; i++) if (base + i >= got.size() || got[base+i] !== 8'(i + 1)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL stream_order got=%0d wrong exp=0", errs); end
    if (ok) begin
      total++; if (got_cyc[base+15] - got_cyc[base] != 15) begin bad++; $display("FAIL stream_rate got=%0d exp=15", got_cyc[base+15] - got_cyc[base]); end
    end
    delivered += 16;
    step();
    total++; if (rd_count !== 4'(delivered)) begin bad++; $display("FAIL stream_rd_count got=%0d exp=%0d", rd_count, 4'(delivered)); end
  endtask

  task automatic test_backpressure();
    int base, errs;
    bit ok;
    m_ready = 1'b0;
    base = got.size();
    for (int i = 0; i < 4; i++) put(8'h21 + 8'(i));
    step(6);
    total++; if (wr_ptr - rd_ptr != 2) begin bad++; $display("FAIL bp_fifo_left got=%0d exp=2", wr_ptr - rd_ptr); end
    total++; if (m_valid !== 1'b1 || m_data !== 8'h21) begin bad++; $display("FAIL bp_head got=%0b/%0h exp=1/21", m_valid, m_data); end
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL bp_rd_en got=%0b exp=0", fifo_rd_en); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%0b exp=1", busy); end
    m_ready = 1'b1;
    wait_got(base + 4, 20, ok);
    step(3);
    total++; if (got.size() != base + 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", got.size() - base); end
    errs = 0;
    for (int i = 0; i < 4; i++) if (base + i >= got.size() || got[base+i] !== 8'h21 + 8'(i)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL bp_order got=%0d wrong exp=0", errs); end
    delivered += 4;
  endtask

  task automatic test_toggle();
    int base, errs;
    base = got.size();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) put(8'h31 + 8'(i));
    for (int i = 0; i < 80 && got.size() < base + 10; i++) begin
      step();
      m_ready = ~m_ready;
    end
    m_ready = 1'b0;
    step(3);
    total++; if (got.size() != base + 10) begin bad++; $display("FAIL toggle_count got=%0d exp=10", got.size() - base); end
    errs = 0;
    for (int i = 0; i < 10; i++) if (base + i >= got.size() || got[base+i] !== 8'h31 + 8'(i)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL toggle_order got=%0d wrong exp=0", errs); end
    delivered += 10;
    total++; if (rd_count !== 4'(delivered)) begin bad++; $display("FAIL toggle_rd_count got=%0d exp=%0d", rd_count, 4'(delivered)); end
  endtask

  task automatic test_flush();
    int base, errs;
    bit ok;
    m_ready = 1'b0;
    base = got.size();
    for (int i = 0; i < 5; i++) put(8'h41 + 8'(i));
    step(2);
    total++; if (m_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL flush_pre got=%0b/%0b exp=1/1", m_valid, busy); end
    flush = 1'b1;
    m_ready = 1'b1;
    #1;
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL flush_rd_en got=%0b exp=0", fifo_rd_en); end
    step();
    total++; if (m_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_clear got=%0b/%0b exp=0/0", m_valid, busy); end
    total++; if (rd_count !== 4'(delivered)) begin bad++; $display("FAIL flush_rd_count got=%0d exp=%0d", rd_count, 4'(delivered)); end
    flush = 1'b0;
    wait_got(base + 3, 20, ok);
    step(3);
    total++; if (got.size() != base + 3) begin bad++; $display("FAIL flush_count got=%0d exp=3", got.size() - base); end
    errs = 0;
    for (int i = 0; i < 3; i++) if (base + i >= got.size() || got[base+i] !== 8'h43 + 8'(i)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL flush_order got=%0d wrong exp=0", errs); end
    delivered += 3;
    total++; if (rd_count !== 4'(delivered)) begin bad++; $display("FAIL flush_after_count got=%0d exp=%0d", rd_count, 4'(delivered)); end
  endtask

  task automatic test_wrap_and_reset();
    int base, errs;
    bit ok;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    delivered = 0;
    step();
    base = got.size();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) put(8'h51 + 8'(i));
    wait_got(base + 17, 50, ok);
    step(2);
    total++; if (rd_count !== 4'd1) begin bad++; $display("FAIL wrap_rd_count got=%0d exp=1", rd_count); end
    errs = 0;
    for (int i = 0; i < 17; i++) if (base + i >= got.size() || got[base+i] !== 8'h51 + 8'(i)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL wrap_order got=%0d wrong exp=0", errs); end
    for (int i = 0; i < 8; i++) put(8'h61 + 8'(i));
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL async_m_valid got=%0b exp=0", m_valid); end
    total++; if (rd_count !== 4'd0) begin bad++; $display("FAIL async_rd_count got=%0d exp=0", rd_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%0b exp=0", busy); end
    step(2);
    rst_n = 1'b1;
    step(3);
    total++; if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin bad++; $display("FAIL post_reset got=%0b/%0b exp=0/0", m_valid, fifo_rd_en); end
  endtask

  task automatic test_invariants();
    total++; if (popped_empty !== 1'b0) begin bad++; $display("FAIL never_pop_empty got=%0b exp=0", popped_empty); end
    total++; if (occ_err !== 1'b0) begin bad++; $display("FAIL occupancy_le_2 got=%0b exp=0", occ_err); end
    total++; if (hold_err !== 1'b0) begin bad++; $display("FAIL stall_stable got=%0b exp=0", hold_err); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_flush();
    test_wrap_and_reset();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
